unary_window_capture: RTL and testbench

//  Downstream consumer of a unary bitstream in the outer-product datapath.

---
 rtl/unary_window_capture.sv | 151 +++++++++++++++
 tb/tb_unary_window_capture.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/unary_window_capture.sv
// ---------------------------------------------------------------------------
// unary_window_capture
//
// Purpose:
//   Counts the ones in a window of 2**BITWIDTH accepted bits of a unary
//   bitstream and hands the binary count downstream over a valid/ready
//   handshake. The output register is one deep: if a window finishes while
//   the previous count is still unaccepted, the result is parked internally
//   and the bitstream is stalled until the sink frees the slot.
//
// Ports:
//   iClk     in   1            clock, all state on posedge
//   iRst     in   1            synchronous reset, active-high
//   iStart   in   1            open a new window (honoured only in IDLE)
//   iBit     in   1            unary stream bit
//   iBitVld  in   1            iBit valid this cycle
//   oBitRdy  out  1            bit consumed when iBitVld & oBitRdy
//   oBusy    out  1            a window is open or a result is parked
//   oCnt     out  BITWIDTH+1   number of ones in the last window
//   oCntVld  out  1            oCnt valid, held until accepted
//   iCntRdy  in   1            sink takes oCnt when oCntVld & iCntRdy
//
// State table:
//   state | meaning
//   IDLE  | no window open; waits for iStart
//   ACC   | window open; consumes bits and counts ones
//   HOLD  | window done but output slot occupied; result parked in acc
// ---------------------------------------------------------------------------
`ifndef BITWIDTH
`define BITWIDTH 4
`endif

module unary_window_capture #(
    parameter int BITWIDTH = `BITWIDTH
) (
    input  logic                iClk,
    input  logic                iRst,
    input  logic                iStart,
    input  logic                iBit,
    input  logic                iBitVld,
    output logic                oBitRdy,
    output logic                oBusy,
    output logic [BITWIDTH:0]   oCnt,
    output logic                oCntVld,
    input  logic                iCntRdy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [BITWIDTH-1:0] CYC_LAST = {BITWIDTH{1'b1}};
    localparam logic [BITWIDTH-1:0] CYC_ONE  = BITWIDTH'(1);

    state_t                state;
    state_t                stateNext;
    logic [BITWIDTH:0]     acc;
    logic [BITWIDTH:0]     accNext;
    logic [BITWIDTH:0]     accSum;
    logic [BITWIDTH-1:0]   cyc;
    logic [BITWIDTH-1:0]   cycNext;
    logic [BITWIDTH:0]     cntNext;
    logic                  cntVldNext;
    logic                  slotFree;

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state   <= IDLE;
            acc     <= '0;
            cyc     <= '0;
            oCnt    <= '0;
            oCntVld <= 1'b0;
        end else begin
            state   <= stateNext;
            acc     <= accNext;
            cyc     <= cycNext;
            oCnt    <= cntNext;
            oCntVld <= cntVldNext;
        end
    end

    // The slot counts as free in the same cycle the sink takes the old value,
    // which is what lets a sink holding iCntRdy high see no bubble.
    assign slotFree = !oCntVld || iCntRdy;
    assign accSum   = acc + (BITWIDTH+1)'(iBit);

    always_comb begin
        stateNext  = state;
        accNext    = acc;
        cycNext    = cyc;
        cntNext    = oCnt;
        cntVldNext = oCntVld;
        oBitRdy    = 1'b0;
        oBusy      = 1'b0;

        // Accept of the current value; a load below overrides this.
        if (oCntVld && iCntRdy) begin
            cntVldNext = 1'b0;
        end

        case (state)
            IDLE: begin
                if (iStart) begin
                    accNext   = '0;
                    cycNext   = '0;
                    stateNext = ACC;
                end
            end

            ACC: begin
                oBitRdy = 1'b1;
                oBusy   = 1'b1;
                if (iBitVld) begin
                    // cyc wraps to zero exactly on the terminal bit.
                    cycNext = cyc + CYC_ONE;
                    if (cyc == CYC_LAST) begin
                        if (slotFree) begin
                            cntNext    = accSum;
                            cntVldNext = 1'b1;
                            accNext    = '0;
                            stateNext  = IDLE;
                        end else begin
                            accNext   = accSum;
                            stateNext = HOLD;
                        end
                    end else begin
                        accNext = accSum;
                    end
                end
            end

            HOLD: begin
                oBusy = 1'b1;
                // In HOLD oCntVld is always set, so iCntRdy alone frees the slot.
                if (iCntRdy) begin
                    cntNext    = acc;
                    cntVldNext = 1'b1;
                    accNext    = '0;
                    stateNext  = IDLE;
                end
            end

            default: begin
                stateNext = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_unary_window_capture.sv
module tb_unary_window_capture;

    localparam int BW  = 4;
    localparam int WIN = 1 << BW;

    logic          iClk;
    logic          iRst;
    logic          iStart;
    logic          iBit;
    logic          iBitVld;
    logic          oBitRdy;
    logic          oBusy;
    logic [BW:0]   oCnt;
    logic          oCntVld;
    logic          iCntRdy;

    unary_window_capture #(.BITWIDTH(BW)) dut (
        .iClk    (iClk),
        .iRst    (iRst),
        .iStart  (iStart),
        .iBit    (iBit),
        .iBitVld (iBitVld),
        .oBitRdy (oBitRdy),
        .oBusy   (oBusy),
        .oCnt    (oCnt),
        .oCntVld (oCntVld),
        .iCntRdy (iCntRdy)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    int nChecks = 0;
    int nFails  = 0;
    int cycNum  = 0;

    // Behavioural reference: a window is a list of accepted bits; its result
    // is the sum of that list once it holds WIN entries.
    bit mWin;
    bit mPend;
    int mPendVal;
    int mBits[$];
    bit mOutVld;
    int mOut;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cycNum);
        end
    endfunction

    function automatic void modelStep();
        int s;
        if (iRst) begin
            mWin = 0; mPend = 0; mBits.delete(); mOutVld = 0; mOut = 0;
            return;
        end
        if (mOutVld && iCntRdy) mOutVld = 0;
        if (mPend) begin
            if (iCntRdy) begin
                mOut = mPendVal; mOutVld = 1; mPend = 0; mWin = 0;
            end
        end else if (mWin) begin
            if (iBitVld) begin
                mBits.push_back(int'(iBit));
                if (mBits.size() == WIN) begin
                    s = 0;
                    foreach (mBits[k]) s += mBits[k];
                    mBits.delete();
                    if (!mOutVld) begin
                        mOut = s; mOutVld = 1; mWin = 0;
                    end else begin
                        mPend = 1; mPendVal = s;
                    end
                end
            end
        end else if (iStart) begin
            mWin = 1;
            mBits.delete();
        end
    endfunction

    // Apply one cycle of inputs, advance model with the DUT, compare on negedge.
    task automatic drive(input logic rst, input logic start, input logic b,
                         input logic bv, input logic rdy);
        logic [31:0] expV;
        iRst = rst; iStart = start; iBit = b; iBitVld = bv; iCntRdy = rdy;
        @(posedge iClk);
        modelStep();
        @(negedge iClk);
        cycNum++;
        expV = {24'd0, (mWin && !mPend), mWin, mOutVld, 5'(mOut)};
        check("model", {24'd0, oBitRdy, oBusy, oCntVld, oCnt}, expV);
    endtask

    task automatic runWindow(input logic [15:0] pat, input int gapPct,
                             input logic rdy, input bit startNoise);
        drive(0, 1, 0, 0, rdy);
        for (int i = 0; i < WIN; i++) begin
            for (int g = 0; g < 3 && int'($urandom_range(99)) < gapPct; g++)
                drive(0, startNoise ? 1'($urandom_range(1)) : 1'b0,
                      1'($urandom_range(1)), 0, rdy);
            drive(0, startNoise ? ((i == WIN-1) ? 1'b1 : 1'($urandom_range(1))) : 1'b0,
                  pat[i], 1, rdy);
        end
    endtask

    typedef struct packed {
        logic [15:0] pat;
        logic [7:0]  gapPct;
        logic [4:0]  expCnt;
    } winVec_t;

    winVec_t vecs[7];

    initial begin
        vecs[0] = '{pat: 16'hFFFF, gapPct: 8'd0,  expCnt: 5'd16};
        vecs[1] = '{pat: 16'h0000, gapPct: 8'd0,  expCnt: 5'd0};
        vecs[2] = '{pat: 16'h5555, gapPct: 8'd0,  expCnt: 5'd8};
        vecs[3] = '{pat: 16'hFFFF, gapPct: 8'd45, expCnt: 5'd16};
        vecs[4] = '{pat: 16'h8000, gapPct: 8'd20, expCnt: 5'd1};
        vecs[5] = '{pat: 16'h1234, gapPct: 8'd20, expCnt: 5'd5};
        vecs[6] = '{pat: 16'hFFFE, gapPct: 8'd30, expCnt: 5'd15};

        mWin = 0; mPend = 0; mOutVld = 0; mOut = 0; mPendVal = 0;
        iRst = 1; iStart = 0; iBit = 0; iBitVld = 0; iCntRdy = 0;

        drive(1, 0, 0, 0, 0);
        drive(1, 1, 1, 1, 1);
        check("reset outputs", {oBitRdy, oBusy, oCntVld, oCnt}, 8'd0);

        // Table-driven windows with a sink that is always ready.
        foreach (vecs[k]) begin
            runWindow(vecs[k].pat, int'(vecs[k].gapPct), 1'b1, 1'b0);
            check($sformatf("vec%0d cnt", k), 32'(oCnt), 32'(vecs[k].expCnt));
            check($sformatf("vec%0d vld", k), 32'(oCntVld), 32'd1);
            check($sformatf("vec%0d busy at close", k), 32'(oBusy), 32'd0);
            drive(0, 0, 1, 1, 1);
            check($sformatf("vec%0d vld one cycle", k), 32'(oCntVld), 32'd0);
            check($sformatf("vec%0d idle rdy", k), 32'(oBitRdy), 32'd0);
        end

        // Back-pressure: A parks in the slot, B parks in HOLD.
        runWindow(16'h001F, 0, 1'b0, 1'b0);
        check("bp A cnt", 32'(oCnt), 32'd5);
        runWindow(16'h01FF, 10, 1'b0, 1'b1);
        check("bp hold busy", 32'(oBusy), 32'd1);
        check("bp hold bitRdy", 32'(oBitRdy), 32'd0);
        check("bp hold cnt A", 32'(oCnt), 32'd5);
        for (int i = 0; i < 4; i++) drive(0, 1, 1, 1, 0);
        check("bp still held", 32'({oCntVld, oCnt}), 32'({1'b1, 5'd5}));
        drive(0, 0, 0, 0, 1);
        check("bp B cnt", 32'(oCnt), 32'd9);
        check("bp B vld", 32'(oCntVld), 32'd1);
        check("bp idle", 32'(oBusy), 32'd0);
        drive(0, 0, 0, 0, 1);
        check("bp drained", 32'(oCntVld), 32'd0);

        // Reset mid-window with a pending result discards both.
        runWindow(16'h0F0F, 0, 1'b0, 1'b0);
        check("pre-reset cnt", 32'(oCnt), 32'd8);
        drive(0, 1, 0, 0, 0);
        for (int i = 0; i < 7; i++) drive(0, 0, 1, 1, 0);
        drive(1, 1, 1, 1, 1);
        check("mid reset outputs", {oBitRdy, oBusy, oCntVld, oCnt}, 8'd0);
        runWindow(16'hFFFF, 0, 1'b1, 1'b0);
        check("post reset cnt", 32'(oCnt), 32'd16);

        // Start pulses inside an open window must not restart it.
        drive(0, 0, 0, 0, 1);
        runWindow(16'hFFFF, 30, 1'b1, 1'b1);
        check("ignored start cnt", 32'(oCnt), 32'd16);
        check("start on close ignored", 32'(oBusy), 32'd0);

        // Random traffic against the reference model.
        for (int i = 0; i < 4000; i++) begin
            drive(($urandom_range(299) == 0) ? 1'b1 : 1'b0,
                  ($urandom_range(3) == 0) ? 1'b1 : 1'b0,
                  1'($urandom_range(1)),
                  ($urandom_range(3) != 0) ? 1'b1 : 1'b0,
                  ($urandom_range(2) != 0) ? 1'b1 : 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
